// File: rtl/ksa_sub_pipe.sv
// Three-stage pipelined 32-bit adder/subtractor built on a radix-2 Kogge-Stone
// carry tree, with a global-stall valid/ready handshake and result flags.
module ksa_sub_pipe #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_sub,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_s,
   output logic             o_borrow,
   output logic             o_zero,
   output logic             o_neg,
   output logic             o_ovf,
   output logic             o_lt
);

   localparam int unsigned MSB = WIDTH - 1;

   generate
      if (WIDTH != 32) begin : g_width_check
         $error("ksa_sub_pipe: only WIDTH == 32 is supported");
      end
   endgenerate

   // One Kogge-Stone level: combine each position with the one 'span' below it.
   function automatic logic [2*WIDTH-1:0] ks_level(input logic [WIDTH-1:0] g,
                                                   input logic [WIDTH-1:0] p,
                                                   input int unsigned      span);
      logic [WIDTH-1:0] low;
      low = ~({WIDTH{1'b1}} << span);
      return {g | (p & (g << span)), p & ((p << span) | low)};
   endfunction

   // Whole pipe advances together; a full output stage blocks everything behind it.
   logic adv;
   assign adv     = ~o_valid | i_ready;
   assign o_ready = i_rst | adv;

   // Stage 1 inputs: c0 is folded into bit 0 as generate from position -1.
   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] p_in;
   logic [WIDTH-1:0] g_in;

   always_comb begin
      b_x     = i_b ^ {WIDTH{i_sub}};
      p_in    = i_a ^ b_x;
      g_in    = i_a & b_x;
      g_in[0] = g_in[0] | (p_in[0] & i_sub);
   end

   logic             v1;
   logic [WIDTH-1:0] p1;
   logic [WIDTH-1:0] g1;
   logic             c0_1;
   logic             a_msb1;
   logic             b_msb1;
   logic             sub1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v1     <= 1'b0;
         p1     <= '0;
         g1     <= '0;
         c0_1   <= 1'b0;
         a_msb1 <= 1'b0;
         b_msb1 <= 1'b0;
         sub1   <= 1'b0;
      end else if (adv) begin
         v1 <= i_valid;
         if (i_valid) begin
            p1     <= p_in;
            g1     <= g_in;
            c0_1   <= i_sub;
            a_msb1 <= i_a[MSB];
            b_msb1 <= b_x[MSB];
            sub1   <= i_sub;
         end
      end
   end

   // Prefix levels at spans 1, 2 and 4.
   logic [WIDTH-1:0] g_l1, p_l1, g_l2, p_l2, g_l3, p_l3;

   always_comb begin
      {g_l1, p_l1} = ks_level(g1, p1, 1);
      {g_l2, p_l2} = ks_level(g_l1, p_l1, 2);
      {g_l3, p_l3} = ks_level(g_l2, p_l2, 4);
   end

   logic             v2;
   logic [WIDTH-1:0] p2;
   logic [WIDTH-1:0] gg2;
   logic [WIDTH-1:0] gp2;
   logic             c0_2;
   logic             a_msb2;
   logic             b_msb2;
   logic             sub2;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v2     <= 1'b0;
         p2     <= '0;
         gg2    <= '0;
         gp2    <= '0;
         c0_2   <= 1'b0;
         a_msb2 <= 1'b0;
         b_msb2 <= 1'b0;
         sub2   <= 1'b0;
      end else if (adv) begin
         v2 <= v1;
         if (v1) begin
            p2     <= p1;
            gg2    <= g_l3;
            gp2    <= p_l3;
            c0_2   <= c0_1;
            a_msb2 <= a_msb1;
            b_msb2 <= b_msb1;
            sub2   <= sub1;
         end
      end
   end

   // Spans 8 and 16 complete the tree; the last level only needs generate.
   logic [WIDTH-1:0] g_l4, p_l4, g_l5;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf_n;

   always_comb begin
      {g_l4, p_l4} = ks_level(gg2, gp2, 8);
      g_l5         = g_l4 | (p_l4 & (g_l4 << 16));
      carry        = {g_l5[MSB-1:0], c0_2};
      sum          = p2 ^ carry;
      cout         = g_l5[MSB];
      ovf_n        = (a_msb2 == b_msb2) & (sum[MSB] != a_msb2);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid  <= 1'b0;
         o_s      <= '0;
         o_borrow <= 1'b0;
         o_zero   <= 1'b0;
         o_neg    <= 1'b0;
         o_ovf    <= 1'b0;
         o_lt     <= 1'b0;
      end else if (adv) begin
         o_valid <= v2;
         if (v2) begin
            o_s      <= sum;
            o_borrow <= cout ^ sub2;
            o_zero   <= (sum == '0);
            o_neg    <= sum[MSB];
            o_ovf    <= ovf_n;
            o_lt     <= sub2 & (sum[MSB] ^ ovf_n);
         end
      end
   end

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Directed and randomised checks for ksa_sub_pipe: arithmetic/flags, latency,
// back-to-back throughput, stall freeze and mid-flight reset.
module tb_ksa_sub_pipe;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_sub   = 1'b0;
   logic [31:0] i_a     = '0;
   logic [31:0] i_b     = '0;
   logic        i_ready = 1'b1;
   logic        o_ready;
   logic        o_valid;
   logic [31:0] o_s;
   logic        o_borrow, o_zero, o_neg, o_ovf, o_lt;

   int          rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
   int          n_tests  = 0;
   int          n_fail   = 0;
   logic [36:0] exp_q[$];
   string       tag_q[$];
   int          run_len  = 0;
   int          max_run  = 0;
   logic [36:0] mon_e;
   string       mon_t;

   always #5 clk = ~clk;

   ksa_sub_pipe #(.WIDTH(32)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_sub    (i_sub),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_s      (o_s),
      .o_borrow (o_borrow),
      .o_zero   (o_zero),
      .o_neg    (o_neg),
      .o_ovf    (o_ovf),
      .o_lt     (o_lt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [36:0] exp_of(input logic borrow, input logic zero, input logic neg,
                                          input logic ovf, input logic lt, input logic [31:0] s);
      return {borrow, zero, neg, ovf, lt, s};
   endfunction

   // 33-bit reference arithmetic, flags derived from signed/unsigned semantics
   function automatic logic [36:0] model(input logic sub, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] r;
      logic        ovf;
      logic        lt;
      r   = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      ovf = sub ? ((a[31] != b[31]) && (r[31] != a[31])) : ((a[31] == b[31]) && (r[31] != a[31]));
      lt  = sub ? ($signed(a) < $signed(b)) : 1'b0;
      return exp_of(r[32], r[31:0] == 32'd0, r[31], ovf, lt, r[31:0]);
   endfunction

   initial forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         0:       i_ready = 1'b0;
         1:       i_ready = 1'b1;
         default: i_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Output monitor: every handshaken beat must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst) begin
         if (o_valid) run_len++;
         else run_len = 0;
         if (run_len > max_run) max_run = run_len;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_beat", 64'(exp_q.size()), 64'd1);
            end else begin
               mon_e = exp_q.pop_front();
               mon_t = tag_q.pop_front();
               check(mon_t, 64'({o_borrow, o_zero, o_neg, o_ovf, o_lt, o_s}), 64'(mon_e));
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic sub, input logic [31:0] a, input logic [31:0] b,
                       input logic [36:0] e, input string tag);
      int guard;
      guard   = 0;
      i_valid = 1'b1;
      i_sub   = sub;
      i_a     = a;
      i_b     = b;
      @(negedge clk);
      while (!o_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!o_ready) check("accept_timeout", 64'(o_ready), 64'd1);
      else begin
         exp_q.push_back(e);
         tag_q.push_back(tag);
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_sub   = 1'bx;
      i_a     = 'x;
      i_b     = 'x;
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_valid && n < 20);
   endtask

   initial begin
      int          n;
      logic [31:0] ra, rb;
      logic        rs;

      repeat (3) @(posedge clk);
      #1;
      check("rst_o_valid", 64'(o_valid), 64'd0);
      check("rst_outputs", 64'({o_borrow, o_zero, o_neg, o_ovf, o_lt, o_s}), 64'd0);
      check("rst_o_ready", 64'(o_ready), 64'd1);
      rst = 1'b0;
      idle(1);

      // single beat and latency
      send(1'b1, 32'd5, 32'd3, exp_of(0, 0, 0, 0, 0, 32'd2), "sub_5_3");
      wait_valid(n);
      check("latency_first", 64'(n), 64'd3);
      idle(5);

      // flag corner cases, back to back
      send(1'b1, 32'd3, 32'd5, exp_of(1, 0, 1, 0, 1, 32'hFFFF_FFFE), "sub_3_5");
      send(1'b1, 32'h1234, 32'h1234, exp_of(0, 1, 0, 0, 0, 32'h0), "sub_eq");
      send(1'b1, 32'h8000_0000, 32'd1, exp_of(0, 0, 0, 1, 1, 32'h7FFF_FFFF), "sub_min_1");
      send(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, exp_of(0, 0, 1, 1, 0, 32'hFFFF_FFFE), "add_max_max");
      send(1'b0, 32'hFFFF_FFFF, 32'd1, exp_of(1, 1, 0, 0, 0, 32'h0), "add_wrap");
      idle(6);
      check("directed_drained", 64'(exp_q.size()), 64'd0);

      // eight beats back to back must give eight consecutive valid cycles
      max_run = 0;
      for (int i = 0; i < 8; i++) begin
         ra = 32'(i * 32'h1111_0000 + 7);
         rb = 32'(i * 3);
         send(1'(i % 2), ra, rb, model(1'(i % 2), ra, rb), $sformatf("b2b_%0d", i));
      end
      idle(6);
      check("b2b_run", 64'(max_run), 64'd8);
      check("b2b_drained", 64'(exp_q.size()), 64'd0);

      // stall with three beats in flight
      rdy_mode = 0;
      send(1'b1, 32'd100, 32'd1, exp_of(0, 0, 0, 0, 0, 32'd99), "stall_0");
      send(1'b0, 32'd10, 32'd20, exp_of(0, 0, 0, 0, 0, 32'd30), "stall_1");
      send(1'b1, 32'd0, 32'd1, exp_of(1, 0, 1, 0, 1, 32'hFFFF_FFFF), "stall_2");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_o_valid", 64'(o_valid), 64'd1);
         check("stall_o_ready", 64'(o_ready), 64'd0);
         check("stall_o_s", 64'(o_s), 64'd99);
      end
      rdy_mode = 1;
      idle(7);
      check("stall_drained", 64'(exp_q.size()), 64'd0);

      // reset with three beats in flight discards them
      rdy_mode = 0;
      send(1'b0, 32'd1, 32'd2, exp_of(0, 0, 0, 0, 0, 32'd3), "lost_0");
      send(1'b0, 32'd3, 32'd4, exp_of(0, 0, 0, 0, 0, 32'd7), "lost_1");
      send(1'b0, 32'd5, 32'd6, exp_of(0, 0, 0, 0, 0, 32'd11), "lost_2");
      rst     = 1'b1;
      i_valid = 1'b1;
      i_sub   = 1'b0;
      i_a     = 32'hDEAD_0000;
      i_b     = 32'h0000_BEEF;
      #1;
      check("rst_busy_o_ready", 64'(o_ready), 64'd1);
      exp_q.delete();
      tag_q.delete();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      i_valid  = 1'b0;
      rdy_mode = 1;
      check("rst_mid_outputs", 64'({o_borrow, o_zero, o_neg, o_ovf, o_lt, o_s}), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_o_valid", 64'(o_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      send(1'b0, 32'd1, 32'd1, exp_of(0, 0, 0, 0, 0, 32'd2), "post_rst");
      wait_valid(n);
      check("latency_post_rst", 64'(n), 64'd3);
      idle(5);
      check("rst_drained", 64'(exp_q.size()), 64'd0);

      // random operands, random gaps and random backpressure
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom();
         rb = (i % 10 == 0) ? ra : $urandom();
         send(rs, ra, rb, model(rs, ra, rb), "random");
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      rdy_mode = 1;
      idle(8);
      check("random_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
